// File: rtl/onewire_if.sv
// onewire_if: host-side command/response bundle for the 1-Wire byte master.
//   cmd_valid/cmd_ready : command handshake, accepted when both are high
//   cmd                 : 0 reset/presence, 1 write byte, 2 read byte, 3 no-op
//   wdata               : byte to write, captured at acceptance
//   rdata               : last byte read, held until the next read completes
//   presence            : result of the last presence window
//   rsp_valid           : one-cycle completion pulse
//   busy                : inverse of cmd_ready
interface onewire_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       presence;
  logic       rsp_valid;
  logic       busy;

  modport master (
    output cmd_valid, cmd, wdata,
    input  cmd_ready, rdata, presence, rsp_valid, busy
  );

  modport slave (
    input  cmd_valid, cmd, wdata,
    output cmd_ready, rdata, presence, rsp_valid, busy
  );
endinterface

// File: rtl/onewire_master.sv
// onewire_master: byte-level 1-Wire bus master. Generates reset/presence,
// write and read time slots on an open-drain DQ line from a 1 us tick.
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high
//   host   : command/response bundle (slave side of onewire_if)
//   ow_oe  : 1 = pull DQ low (tri-state enable of the pad cell)
//   ow_in  : raw DQ pad input, asynchronous to clk
//
// state | meaning
// IDLE  | waiting for a command, DQ released
// RST   | 960 us reset/presence slot
// SLOT  | one of eight 70 us write or read slots
// DONE  | one-cycle completion, rsp_valid high
module onewire_master #(
  parameter int TICK_DIV = 29
) (
  input  logic clk,
  input  logic reset,
  onewire_if.slave host,
  output logic ow_oe,
  input  logic ow_in
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RST, SLOT, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q;
  logic [9:0]    t_q;
  logic [2:0]    bit_q;
  logic [7:0]    sreg_q;
  logic          is_read_q;
  logic          presence_q;
  logic [7:0]    rdata_q;
  logic [1:0]    sync_q;

  logic       ow_s;
  logic       tick;
  logic       accept;
  logic       cmd_ready;
  logic       rsp_valid;
  logic       slot_next;
  logic [9:0] low_len;

  assign ow_s   = sync_q[1];
  assign tick   = (presc_q == PW'(TICK_DIV - 1));
  assign accept = host.cmd_valid & cmd_ready;

  // Only a write-0 slot holds DQ low for 60 us; write-1 and read use 6 us.
  assign low_len = (!is_read_q && !sreg_q[bit_q]) ? 10'd60 : 10'd6;

  always_comb begin
    state_d   = state_q;
    ow_oe     = 1'b0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    slot_next = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (host.cmd_valid) begin
          unique case (host.cmd)
            2'd0:       state_d = RST;
            2'd1, 2'd2: state_d = SLOT;
            default:    state_d = DONE;
          endcase
        end
      end
      RST: begin
        ow_oe = (t_q < 10'd480);
        if (tick && t_q == 10'd959) state_d = DONE;
      end
      SLOT: begin
        ow_oe = (t_q < low_len);
        if (tick && t_q == 10'd69) begin
          if (bit_q == 3'd7) state_d = DONE;
          else               slot_next = 1'b1;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      t_q        <= '0;
      bit_q      <= '0;
      sreg_q     <= '0;
      is_read_q  <= 1'b0;
      presence_q <= 1'b0;
      rdata_q    <= '0;
      sync_q     <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], ow_in};

      if (state_q == IDLE || tick) presc_q <= '0;
      else                         presc_q <= presc_q + PW'(1);

      if (accept || slot_next) t_q <= '0;
      else if (tick)           t_q <= t_q + 10'd1;

      if (accept) begin
        bit_q     <= '0;
        is_read_q <= (host.cmd == 2'd2);
        sreg_q    <= (host.cmd == 2'd1) ? host.wdata : 8'h00;
      end else if (slot_next) begin
        bit_q <= bit_q + 3'd1;
      end else if (state_q == SLOT && is_read_q && tick && t_q == 10'd14) begin
        // LSB arrives first, so after eight shifts it sits in bit 0.
        sreg_q <= {ow_s, sreg_q[7:1]};
      end

      if (state_q == RST && tick && t_q == 10'd550) presence_q <= ~ow_s;

      // Loaded on entry to DONE so rdata is already valid alongside rsp_valid.
      if (state_q == SLOT && state_d == DONE && is_read_q) rdata_q <= sreg_q;
    end
  end

  assign host.cmd_ready = cmd_ready;
  assign host.busy      = ~cmd_ready;
  assign host.rsp_valid = rsp_valid;
  assign host.rdata     = rdata_q;
  assign host.presence  = presence_q;

endmodule

// File: tb/tb_onewire_master.sv
module tb_onewire_master;
  localparam int TD = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ow_oe;
  logic ow_in;

  onewire_if host_if ();

  onewire_master #(.TICK_DIV(TD)) dut (
    .clk   (clk),
    .reset (reset),
    .host  (host_if),
    .ow_oe (ow_oe),
    .ow_in (ow_in)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural slave device: answers presence in 500..620 us after the
  // reset pulse starts, and during read slots holds DQ low to 30 us for 0 bits.
  logic       dev_present = 1'b0;
  logic [7:0] dev_byte = 8'h00;
  logic [1:0] last_cmd = 2'd3;
  logic       oe_prev = 1'b0;
  logic       cur_bit = 1'b1;
  int         since = 100000;
  int         rise_cnt = 0;
  logic       dev_pull;

  always @(posedge clk) begin
    oe_prev <= ow_oe;
    if (host_if.cmd_valid && host_if.cmd_ready) begin
      last_cmd <= host_if.cmd;
      rise_cnt <= 0;
    end else if (ow_oe && !oe_prev) begin
      since    <= 0;
      cur_bit  <= dev_byte[rise_cnt[2:0]];
      rise_cnt <= rise_cnt + 1;
    end else if (since < 100000) begin
      since <= since + 1;
    end
  end

  assign dev_pull = (last_cmd == 2'd0 && dev_present && since >= 500*TD && since < 620*TD) ||
                    (last_cmd == 2'd2 && !cur_bit && since < 30*TD);
  assign ow_in = ~(ow_oe | dev_pull);

  logic [7:0] exp_rdata = 8'h00;
  logic       exp_presence = 1'b0;

  // Expected DQ drive at sample k (k=1 is the first cycle after acceptance).
  function automatic logic oe_model(input logic [1:0] c, input logic [7:0] wd, input int k);
    int slot, off;
    if (c == 2'd0) return (k >= 1 && k <= 480*TD);
    if (c == 2'd1 || c == 2'd2) begin
      slot = (k - 1) / (70*TD);
      off  = (k - 1) % (70*TD);
      if (slot > 7) return 1'b0;
      return off < (((c == 2'd1) && !wd[slot[2:0]]) ? 60*TD : 6*TD);
    end
    return 1'b0;
  endfunction

  task automatic run(input logic [1:0] c, input logic [7:0] wd, input bit hold);
    int exp_k, budget, st, ready_k, rd_early;
    int starts[$], widths[$], rsps[$], exp_s[$], exp_w[$];
    logic prev;
    logic [7:0] rd0, rd_at_rsp, exp_rd;
    st = 0; ready_k = -1; rd_early = 0; prev = 1'b0; rd_at_rsp = 8'h00;
    case (c)
      2'd0: begin
        exp_k = 960*TD + 1;
        exp_s.push_back(1);
        exp_w.push_back(480*TD);
      end
      2'd1, 2'd2: begin
        exp_k = 560*TD + 1;
        for (int i = 0; i < 8; i++) begin
          exp_s.push_back(1 + i*70*TD);
          exp_w.push_back((c == 2'd1 && !wd[i]) ? 60*TD : 6*TD);
        end
      end
      default: exp_k = 1;
    endcase
    exp_rd = (c == 2'd2) ? dev_byte : exp_rdata;
    if (c == 2'd0) exp_presence = dev_present;

    @(negedge clk);
    host_if.cmd_valid = 1'b1;
    host_if.cmd       = c;
    host_if.wdata     = wd;
    chk("ready_at_issue", host_if.cmd_ready, 1);
    rd0 = host_if.rdata;
    @(posedge clk);
    budget = exp_k + (hold ? 6 : 4);
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (hold) host_if.cmd = 2'd3;
        else      host_if.cmd_valid = 1'b0;
      end
      if (ow_oe && !prev) st = k;
      if (!ow_oe && prev) begin
        starts.push_back(st);
        widths.push_back(k - st);
      end
      prev = ow_oe;
      if (host_if.rsp_valid) begin
        if (rsps.size() == 0) rd_at_rsp = host_if.rdata;
        rsps.push_back(k);
      end
      if (k < exp_k && host_if.rdata !== rd0) rd_early++;
      if (rsps.size() > 0 && ready_k < 0 && host_if.cmd_ready) ready_k = k;
      if (hold && ready_k > 0 && k == ready_k + 1) host_if.cmd_valid = 1'b0;
    end
    host_if.cmd_valid = 1'b0;

    chk("rsp_count", rsps.size(), hold ? 2 : 1);
    chk("rsp_cycle", (rsps.size() > 0) ? rsps[0] : -1, exp_k);
    if (hold) chk("held_rsp_cycle", (rsps.size() > 1) ? rsps[1] : -1, exp_k + 2);
    chk("ready_return", ready_k, exp_k + 1);
    chk("pulse_count", widths.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < widths.size(); i++) begin
      chk($sformatf("pulse_w%0d", i), widths[i], exp_w[i]);
      chk($sformatf("pulse_s%0d", i), starts[i], exp_s[i]);
    end
    chk("rdata_at_rsp", rd_at_rsp, exp_rd);
    chk("rdata_stable", rd_early, 0);
    chk("presence", host_if.presence, exp_presence);
    exp_rdata = exp_rd;
  endtask

  task automatic abort_at(input logic [1:0] c, input logic [7:0] wd, input int at_k);
    int cnt;
    cnt = 0;
    @(negedge clk);
    host_if.cmd_valid = 1'b1;
    host_if.cmd       = c;
    host_if.wdata     = wd;
    @(posedge clk);
    for (int k = 1; k <= at_k; k++) begin
      @(negedge clk);
      if (k == 1) host_if.cmd_valid = 1'b0;
    end
    chk("abort_oe_before", ow_oe, oe_model(c, wd, at_k));
    #1 reset = 1'b1;
    #1;
    chk("abort_oe_async", ow_oe, 0);
    chk("abort_ready", host_if.cmd_ready, 1);
    chk("abort_busy", host_if.busy, 0);
    repeat (2) begin
      @(negedge clk);
      if (host_if.rsp_valid) cnt++;
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (host_if.rsp_valid) cnt++;
    end
    chk("abort_no_rsp", cnt, 0);
    exp_presence = 1'b0;
    exp_rdata    = 8'h00;
    chk("abort_presence", host_if.presence, exp_presence);
    chk("abort_rdata", host_if.rdata, exp_rdata);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] c;
    logic [7:0] wd;
    host_if.cmd_valid = 1'b0;
    host_if.cmd       = 2'd0;
    host_if.wdata     = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_oe", ow_oe, 0);
    chk("rst_ready", host_if.cmd_ready, 1);
    chk("rst_busy", host_if.busy, 0);
    chk("rst_rsp", host_if.rsp_valid, 0);
    chk("rst_presence", host_if.presence, 0);
    chk("rst_rdata", host_if.rdata, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    dev_present = 1'b1;
    run(2'd0, 8'h00, 1'b0);
    dev_present = 1'b0;
    run(2'd0, 8'h00, 1'b0);
    run(2'd1, 8'hA5, 1'b0);
    dev_byte = 8'h3C;
    run(2'd2, 8'h00, 1'b0);
    run(2'd3, 8'h00, 1'b0);
    dev_byte = 8'($urandom);
    run(2'd2, 8'h00, 1'b1);

    dev_present = 1'b1;
    abort_at(2'd0, 8'h00, 300*TD);
    run(2'd1, 8'($urandom), 1'b0);
    abort_at(2'd1, 8'($urandom) & 8'hFB, 200*TD);
    run(2'd0, 8'h00, 1'b0);

    for (int i = 0; i < 8; i++) begin
      c           = 2'($urandom_range(0, 3));
      wd          = 8'($urandom);
      dev_byte    = 8'($urandom);
      dev_present = 1'($urandom_range(0, 1));
      run(c, wd, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
